mmio_bus_arbiter: RTL and testbench
===================================

MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, bus cycles per transaction (legal 1..15).
REQ-002 Parameter ADDR_W, default 32, width of address and data paths.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  requester wants one bus transaction (m0 = CPU, m1 = sprite/obstacle mover).
REQ-006 m0_addr / m1_addr  input  ADDR_W  target address (data memory 0x0001..0x0F9F, 0x0FA0 sprite, 0x0FA4 obstacle, 0x0FA8 PS2).
REQ-007 m0_wdata / m1_wdata  input  ADDR_W  write data.
REQ-008 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-009 m0_lock / m1_lock  input  1  keep grant for the immediately following request.
REQ-010 m0_gnt / m1_gnt  output  1  requester owns the bus.
REQ-011 m0_done / m1_done  output  1  one-cycle pulse, transaction complete.
REQ-012 rdata  output  ADDR_W  captured read data, valid in the done cycle and held until next capture.
REQ-013 bus_addr  output  ADDR_W  address to the address decoder and memories.
REQ-014 bus_wdata  output  ADDR_W  shared write data.
REQ-015 bus_we  output  1  memWrite to the address decoder.
REQ-016 bus_rdata  input  ADDR_W  read data from the decoder-selected source.

Function
REQ-017 States: IDLE, ACCESS; state machine SHALL be a registered enum.
REQ-018 In IDLE, any asserted req SHALL be arbitrated; winner latched into addr/wdata/we registers; next cycle state = ACCESS.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset m0 has priority.
REQ-020 gnt of the winner SHALL be high for every ACCESS cycle and low otherwise; at most one gnt high at any time.
REQ-021 ACCESS SHALL last exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter loaded at grant.
REQ-022 bus_addr/bus_wdata/bus_we SHALL carry latched values during ACCESS; in IDLE they SHALL be 0/0/0 (no decoder write enable active).
REQ-023 On the last ACCESS cycle: owner's done SHALL pulse; if we = 0, rdata SHALL capture bus_rdata; state returns to IDLE.
REQ-024 Request-to-done latency SHALL be ACCESS_CYCLES + 1 cycles with no contention.
REQ-025 req deassertion during ACCESS SHALL NOT abort the transaction; changes to addr/wdata/we during ACCESS SHALL be ignored.
REQ-026 A request still high in the cycle after done SHALL be treated as a new request.
REQ-027 Writes SHALL NOT modify rdata.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, all gnt/done 0, bus outputs 0, rdata 0, counter 0, round-robin pointer to m0.
REQ-029 Reset asserted mid-ACCESS SHALL abort silently: no done pulse after release.
REQ-030 First arbitration SHALL occur on the first rising edge with reset_n high.

Configuration
REQ-031 Macro MMIO_ARB_LOCK_EN defined: if owner's lock is high on its done cycle and its req is high in the next IDLE cycle, it SHALL win regardless of the round-robin pointer; the pointer SHALL NOT advance.
REQ-032 Macro MMIO_ARB_LOCK_EN undefined: m0_lock/m1_lock ports SHALL exist but be ignored; pure round-robin.

Structure
REQ-033 Shared package mmio_pkg SHALL hold the state enum, MMIO address constants (0x0FA0, 0x0FA4, 0x0FA8, data memory limit 0x0FA0) and default ACCESS_CYCLES.
REQ-034 Round-robin winner selection SHALL be a sub-module rr_arbiter2 (req[1:0], last-served pointer in, one-hot grant out).

Verification
REQ-035 m0 write 0x0FA0 data 0x12 alone -> m0_gnt 2 cycles, bus_we=1 bus_addr=0x0FA0 during grant, m0_done 3 cycles after req.
REQ-036 m0 and m1 request same cycle after reset -> m0 served first, m1 granted in the IDLE cycle after m0_done, then m0 again if still requesting.
REQ-037 m1 read 0x0FA8 with bus_rdata=0xA5 -> rdata=0xA5 in m1_done cycle, held through subsequent writes.
REQ-038 reset_n pulled low in first ACCESS cycle -> gnt, bus outputs 0 immediately; no done after release.
REQ-039 MMIO_ARB_LOCK_EN, m0 lock=1 with both requesting continuously -> m0 served back-to-back; lock=0 -> alternates m0/m1.
REQ-040 IDLE with no requests -> bus_addr=0, bus_we=0 every cycle, no decoder write enable.

Source files
------------

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared types and constants for the MMIO bus arbiter:
//                arbiter state enum, MMIO address map, default access length.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // MMIO address map seen by the address decoder
  localparam logic [31:0] c_addr_sprite   = 32'h0000_0FA0;
  localparam logic [31:0] c_addr_obstacle = 32'h0000_0FA4;
  localparam logic [31:0] c_addr_ps2      = 32'h0000_0FA8;
  // Data memory occupies addresses below this limit
  localparam logic [31:0] c_dmem_limit    = 32'h0000_0FA0;

  localparam int c_default_access_cycles = 2;

endpackage
`default_nettype wire

// File: rtl/mmio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_arbiter_if
//  Description : Requester handshakes and shared bus signals of the MMIO
//                arbiter. slave = arbiter view, master = requester/memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req,   m1_req;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [ADDR_W-1:0] m0_wdata, m1_wdata;
  logic              m0_we,    m1_we;
  logic              m0_lock,  m1_lock;
  logic              m0_gnt,   m1_gnt;
  logic              m0_done,  m1_done;
  logic [ADDR_W-1:0] rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] bus_wdata;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_rdata;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_lock, m1_lock, bus_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
           bus_addr, bus_wdata, bus_we
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_lock, m1_lock, bus_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, rdata,
           bus_addr, bus_wdata, bus_we
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin winner selection. On a tie the requester
//                that was not served last wins. One-hot grant out.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  wire logic [1:0] req,
  input  wire logic       last_served,
  output logic      [1:0] gnt
);

  // Single requester wins outright; a tie goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_arbiter
//  Description : Arbitrates CPU (m0) and sprite/obstacle mover (m1) onto one
//                MMIO bus. IDLE -> ACCESS for ACCESS_CYCLES cycles, registered
//                done pulse and read-data capture on the last access cycle.
//                Optional macro MMIO_ARB_LOCK_EN: owner's lock keeps the bus
//                for its immediately following request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_arbiter
  import mmio_pkg::*;
#(
  parameter int ACCESS_CYCLES = c_default_access_cycles,
  parameter int ADDR_W        = 32
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  mmio_bus_arbiter_if.slave  bus
);

  localparam logic [3:0] c_cnt_load = 4'(ACCESS_CYCLES);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_owner;      // 0 = m0, 1 = m1
  logic              r_rr_ptr;     // requester that wins the next tie
  logic [ADDR_W-1:0] r_addr, r_wdata, r_rdata;
  logic              r_we;
  logic [1:0]        r_done;
  logic [1:0]        w_req, w_rr_gnt, w_win;
  logic              w_last_served, w_lock_hit, w_load, w_last, w_access;

  assign w_req         = {bus.m1_req, bus.m0_req};
  assign w_last_served = ~r_rr_ptr;

  rr_arbiter2 u_rr (
    .req         (w_req),
    .last_served (w_last_served),
    .gnt         (w_rr_gnt)
  );

`ifdef MMIO_ARB_LOCK_EN
  // r_done is high only in the IDLE cycle right after the owner finished,
  // so a lock can only carry over into the very next request.
  logic [1:0] w_lock_req;
  assign w_lock_req = r_done & {bus.m1_lock, bus.m0_lock} & w_req;
  assign w_lock_hit = |w_lock_req;
  assign w_win      = w_lock_hit ? w_lock_req : w_rr_gnt;
`else
  logic unused_lock;
  assign unused_lock = bus.m0_lock ^ bus.m1_lock;
  assign w_lock_hit  = 1'b0;
  assign w_win       = w_rr_gnt;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: grant on any request in IDLE, leave ACCESS when the count ends
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_nxt = S_ACCESS;
          w_load      = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's transaction, run the access counter, pulse done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_owner  <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_rdata  <= '0;
      r_done   <= 2'b00;
    end else begin
      r_done <= 2'b00;
      if (w_load) begin
        r_owner <= w_win[1];
        r_addr  <= w_win[1] ? bus.m1_addr  : bus.m0_addr;
        r_wdata <= w_win[1] ? bus.m1_wdata : bus.m0_wdata;
        r_we    <= w_win[1] ? bus.m1_we    : bus.m0_we;
        r_cnt   <= c_cnt_load;
        if (!w_lock_hit) r_rr_ptr <= ~w_win[1];
      end else if (w_access) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last) begin
        r_done <= r_owner ? 2'b10 : 2'b01;
        if (!r_we) r_rdata <= bus.bus_rdata;
      end
    end
  end

  // Bus drives only during ACCESS so no decoder write enable leaks in IDLE
  assign w_access      = (r_state == S_ACCESS);
  assign bus.m0_gnt    = w_access & ~r_owner;
  assign bus.m1_gnt    = w_access &  r_owner;
  assign bus.bus_addr  = w_access ? r_addr  : '0;
  assign bus.bus_wdata = w_access ? r_wdata : '0;
  assign bus.bus_we    = w_access & r_we;
  assign bus.m0_done   = r_done[0];
  assign bus.m1_done   = r_done[1];
  assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_bus_arbiter
//  Description : Directed self-checking bench for mmio_bus_arbiter
//                (ACCESS_CYCLES = 2). Lock expectations follow MMIO_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_arbiter;
  import mmio_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  mmio_bus_arbiter_if #(.ADDR_W(32)) bus ();

  mmio_bus_arbiter #(
    .ACCESS_CYCLES (2),
    .ADDR_W        (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    bus.m0_addr = '0;  bus.m1_addr = '0;
    bus.m0_wdata = '0; bus.m1_wdata = '0;
    bus.m0_we = 1'b0;  bus.m1_we = 1'b0;
    bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
    bus.bus_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Both masters request from edge 0; requests drop after edge 7.
  // Bit i of each vector is the expected value after edge i+1.
  task automatic run_seq(input string name, input logic [8:0] g0, input logic [8:0] g1,
                         input logic [8:0] d0, input logic [8:0] d1);
    logic [31:0] exp_addr;
    bus.m0_addr = 32'h0000_0010; bus.m0_we = 1'b1; bus.m0_wdata = 32'h11;
    bus.m1_addr = c_addr_obstacle; bus.m1_we = 1'b1; bus.m1_wdata = 32'h22;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_addr = g0[i] ? 32'h0000_0010 : (g1[i] ? c_addr_obstacle : 32'h0);
      check_eq({name, "_m0_gnt"},  32'(bus.m0_gnt),  32'(g0[i]));
      check_eq({name, "_m1_gnt"},  32'(bus.m1_gnt),  32'(g1[i]));
      check_eq({name, "_m0_done"}, 32'(bus.m0_done), 32'(d0[i]));
      check_eq({name, "_m1_done"}, 32'(bus.m1_done), 32'(d1[i]));
      check_eq({name, "_bus_addr"}, bus.bus_addr, exp_addr);
      if (i == 6) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    #12;
    // Reset state
    check_eq("rst_m0_gnt",  32'(bus.m0_gnt),  32'd0);
    check_eq("rst_m1_gnt",  32'(bus.m1_gnt),  32'd0);
    check_eq("rst_done",    32'({bus.m1_done, bus.m0_done}), 32'd0);
    check_eq("rst_bus_we",  32'(bus.bus_we),  32'd0);
    check_eq("rst_bus_addr", bus.bus_addr, 32'd0);
    check_eq("rst_rdata",   bus.rdata,     32'd0);
    tick();
    reset_n = 1'b1;

    // m0 write to sprite register, uncontended
    bus.m0_req = 1'b1; bus.m0_addr = c_addr_sprite; bus.m0_wdata = 32'h12; bus.m0_we = 1'b1;
    tick();
    check_eq("wr_gnt_c1",   32'(bus.m0_gnt), 32'd1);
    check_eq("wr_m1_gnt",   32'(bus.m1_gnt), 32'd0);
    check_eq("wr_we_c1",    32'(bus.bus_we), 32'd1);
    check_eq("wr_addr_c1",  bus.bus_addr,    c_addr_sprite);
    check_eq("wr_wdata_c1", bus.bus_wdata,   32'h12);
    check_eq("wr_done_c1",  32'(bus.m0_done), 32'd0);
    // Changes while in ACCESS must not disturb the transaction
    bus.m0_req = 1'b0; bus.m0_addr = 32'h1234; bus.m0_wdata = 32'h99; bus.m0_we = 1'b0;
    tick();
    check_eq("wr_gnt_c2",   32'(bus.m0_gnt), 32'd1);
    check_eq("wr_addr_c2",  bus.bus_addr,    c_addr_sprite);
    check_eq("wr_wdata_c2", bus.bus_wdata,   32'h12);
    check_eq("wr_done_c2",  32'(bus.m0_done), 32'd0);
    tick();
    check_eq("wr_done_c3",  32'(bus.m0_done), 32'd1);
    check_eq("wr_gnt_c3",   32'(bus.m0_gnt),  32'd0);
    check_eq("wr_we_c3",    32'(bus.bus_we),  32'd0);
    check_eq("wr_addr_c3",  bus.bus_addr,     32'd0);
    tick();
    check_eq("wr_done_c4",  32'(bus.m0_done), 32'd0);
    check_eq("wr_rdata",    bus.rdata,        32'd0);

    // m1 read of PS2 register
    bus.m1_req = 1'b1; bus.m1_addr = c_addr_ps2; bus.m1_we = 1'b0; bus.bus_rdata = 32'hA5;
    tick();
    check_eq("rd_gnt_c1",  32'(bus.m1_gnt), 32'd1);
    check_eq("rd_we_c1",   32'(bus.bus_we), 32'd0);
    check_eq("rd_addr_c1", bus.bus_addr,    c_addr_ps2);
    bus.m1_req = 1'b0;
    tick();
    check_eq("rd_done_c2", 32'(bus.m1_done), 32'd0);
    tick();
    check_eq("rd_done_c3", 32'(bus.m1_done), 32'd1);
    check_eq("rd_rdata",   bus.rdata,        32'hA5);
    // A following write must leave rdata alone
    bus.bus_rdata = 32'h5A;
    bus.m0_req = 1'b1; bus.m0_addr = c_addr_obstacle; bus.m0_wdata = 32'h7; bus.m0_we = 1'b1;
    tick();
    bus.m0_req = 1'b0;
    tick();
    tick();
    check_eq("wr2_done",     32'(bus.m0_done), 32'd1);
    check_eq("rd_rdata_held", bus.rdata,       32'hA5);

    // Simultaneous requests after reset: m0, m1, then m0 again
    do_reset();
    run_seq("rr", 9'b011000011, 9'b000011000, 9'b100000100, 9'b000100000);

    // m0 holding lock while both request continuously
    do_reset();
    bus.m0_lock = 1'b1;
`ifdef MMIO_ARB_LOCK_EN
    run_seq("lock", 9'b011011011, 9'b000000000, 9'b100100100, 9'b000000000);
`else
    run_seq("lock", 9'b011000011, 9'b000011000, 9'b100000100, 9'b000100000);
`endif

    // Reset in the first ACCESS cycle aborts silently
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = c_addr_sprite; bus.m0_wdata = 32'h3C; bus.m0_we = 1'b1;
    tick();
    check_eq("ab_gnt_pre", 32'(bus.m0_gnt), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ab_gnt",      32'(bus.m0_gnt), 32'd0);
    check_eq("ab_bus_we",   32'(bus.bus_we), 32'd0);
    check_eq("ab_bus_addr", bus.bus_addr,    32'd0);
    bus.m0_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ab_no_done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
      check_eq("ab_no_gnt",  32'({bus.m1_gnt, bus.m0_gnt}),   32'd0);
    end

    // IDLE with no requests but stale addresses on the request ports
    bus.m0_addr = c_addr_ps2; bus.m0_we = 1'b1; bus.m1_addr = c_dmem_limit; bus.m1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("idle_bus_addr", bus.bus_addr,    32'd0);
      check_eq("idle_bus_we",   32'(bus.bus_we), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
